// File: rtl/fft_pkg.sv
// Shared FFT helpers: bit reversal, packed-bus field offsets and index-width convention.
// Used by the butterfly, loader and unloader blocks.
package fft_pkg;

  // Width of a sample index for an N-point frame (N >= 2).
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reverse the low log2n bits of idx.
  function automatic int bitrev(int idx, int log2n);
    int r;
    r = 0;
    for (int i = 0; i < log2n; i++) begin
      r = (r << 1) | ((idx >> i) & 1);
    end
    return r;
  endfunction

  // LSB position of sample k's real (is_imag=0) or imag (is_imag=1) field in a packed bus.
  function automatic int sample_lsb(int k, int dw, bit is_imag);
    return dw * (2 * k + (is_imag ? 1 : 0));
  endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// One frame register: captures the whole complex bus on we, reads one sample by index.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [DATA_WIDTH*2*N-1:0]      frame_in,
  input  logic [idx_w(N)-1:0]            idx,
  output logic [DATA_WIDTH-1:0]          rd_real,
  output logic [DATA_WIDTH-1:0]          rd_imag
);

  logic [DATA_WIDTH*2*N-1:0] frame_q;

  // NOTE: data storage has no reset; the owner's full flag decides whether contents are meaningful.
  always_ff @(posedge clk) begin
    if (we) frame_q <= frame_in;
  end

  assign rd_real = frame_q[sample_lsb(int'(idx), DATA_WIDTH, 1'b0) +: DATA_WIDTH];
  assign rd_imag = frame_q[sample_lsb(int'(idx), DATA_WIDTH, 1'b1) +: DATA_WIDTH];

endmodule

// File: rtl/fft_frame_unloader.sv
// Captures a parallel FFT frame into ping-pong buffers and streams it one sample per
// valid/ready beat, in natural or bit-reversed order.
module fft_frame_unloader
  import fft_pkg::*;
#(
  parameter int N           = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int BIT_REVERSE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*2*N-1:0]      cplx_data_in,
  input  logic                           en_in,
  output logic [DATA_WIDTH-1:0]          sample_real,
  output logic [DATA_WIDTH-1:0]          sample_imag,
  output logic [idx_w(N)-1:0]            sample_index,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic                           sample_last,
  output logic                           overflow
);

  localparam int IDX_W = idx_w(N);

  logic [1:0]            full, full_next;
  logic                  wr_sel, rd_sel;
  logic [IDX_W-1:0]      count, rd_slot;
  logic                  beat, last_beat, drain_wr, capture;
  logic [DATA_WIDTH-1:0] buf_real [2];
  logic [DATA_WIDTH-1:0] buf_imag [2];

  assign sample_valid = full[rd_sel];
  assign beat         = sample_valid & sample_ready;
  assign last_beat    = beat & (count == IDX_W'(N - 1));
  // A full write buffer is still usable if its final sample leaves on this same edge.
  assign drain_wr     = last_beat & (rd_sel == wr_sel);
  assign capture      = en_in & ~rst & (~full[wr_sel] | drain_wr);
  assign overflow     = en_in & ~rst & full[wr_sel] & ~drain_wr;

  assign rd_slot = (BIT_REVERSE != 0) ? IDX_W'(bitrev(int'(count), IDX_W)) : count;

  for (genvar i = 0; i < 2; i++) begin : g_buf
    fft_frame_buffer #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
      .clk      (clk),
      .we       (capture && (wr_sel == 1'(i))),
      .frame_in (cplx_data_in),
      .idx      (rd_slot),
      .rd_real  (buf_real[i]),
      .rd_imag  (buf_imag[i])
    );
  end

  assign sample_real  = sample_valid ? buf_real[rd_sel] : '0;
  assign sample_imag  = sample_valid ? buf_imag[rd_sel] : '0;
  assign sample_index = sample_valid ? count : '0;
  assign sample_last  = sample_valid & (count == IDX_W'(N - 1));

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    full_next = full;
    if (last_beat) full_next[rd_sel] = 1'b0;
    if (capture)   full_next[wr_sel] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= '0;
    end else begin
      full <= full_next;
      if (capture) wr_sel <= ~wr_sel;
      if (beat) begin
        if (last_beat) begin
          count  <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_unloader.sv
// Self-checking bench: directed scenarios plus random traffic against a frame-queue model.
module tb_fft_frame_unloader;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int BW = DW * 2 * N;
  localparam int N8  = 8;
  localparam int BW8 = DW * 2 * N8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, ready;
  logic [BW-1:0] data;
  logic [DW-1:0] s_real, s_imag;
  logic [1:0]    s_index;
  logic          s_valid, s_last, ovf;

  logic           en8;
  logic [BW8-1:0] data8;
  logic [DW-1:0]  s_real8, s_imag8;
  logic [2:0]     s_index8;
  logic           s_valid8, s_last8, ovf8;

  fft_frame_unloader #(.N(N), .DATA_WIDTH(DW), .BIT_REVERSE(1)) dut (
    .clk(clk), .rst(rst), .cplx_data_in(data), .en_in(en),
    .sample_real(s_real), .sample_imag(s_imag), .sample_index(s_index),
    .sample_valid(s_valid), .sample_ready(ready), .sample_last(s_last),
    .overflow(ovf)
  );

  fft_frame_unloader #(.N(N8), .DATA_WIDTH(DW), .BIT_REVERSE(0)) dut8 (
    .clk(clk), .rst(rst), .cplx_data_in(data8), .en_in(en8),
    .sample_real(s_real8), .sample_imag(s_imag8), .sample_index(s_index8),
    .sample_valid(s_valid8), .sample_ready(1'b1), .sample_last(s_last8),
    .overflow(ovf8)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: FIFO of accepted frames (at most two) and the slot being offered.
  logic [BW-1:0] mq[$];
  int            mslot = 0;
  int            rev4 [4] = '{0, 2, 1, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] seq_frame(int base);
    logic [BW-1:0] f;
    for (int k = 0; k < N; k++) begin
      f[2*DW*k +: DW]      = DW'(base + k);
      f[2*DW*k + DW +: DW] = DW'(-(base + k));
    end
    return f;
  endfunction

  // Check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    logic [BW-1:0] f;
    logic          ev, edrop;
    int            k;
    @(negedge clk);
    ev    = (mq.size() > 0);
    edrop = en && !rst && (mq.size() == 2) && !(ready && mslot == N - 1);
    check("valid", 32'(s_valid), 32'(ev));
    check("overflow", 32'(ovf), 32'(edrop));
    if (ev) begin
      f = mq[0];
      k = rev4[mslot];
      check("real",  32'(s_real),  32'(f[2*DW*k +: DW]));
      check("imag",  32'(s_imag),  32'(f[2*DW*k + DW +: DW]));
      check("index", 32'(s_index), 32'(mslot));
      check("last",  32'(s_last),  32'(mslot == N - 1));
    end else begin
      check("idle_out", {s_real, s_imag}, 32'd0);
      check("idle_idx_last", {s_index, s_last}, 32'd0);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mslot = 0;
    end else begin
      if (ev && ready) begin
        if (mslot == N - 1) begin
          void'(mq.pop_front());
          mslot = 0;
        end else begin
          mslot++;
        end
      end
      if (en && !edrop) mq.push_back(data);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; data = '0;
    en8 = 1'b0; data8 = '0;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    step();

    // Single frame, consumer always ready: (1,-1),(3,-3),(2,-2),(4,-4).
    ready = 1'b1; en = 1'b1; data = seq_frame(1);
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Same frame with a stalling consumer.
    en = 1'b1; ready = 1'b0;
    step();
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ready = (i % 3 == 0);
      step();
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Three frames back to back with a stalled consumer: third one is dropped.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; data = seq_frame(16 * (i + 1));
      step();
    end
    en = 1'b0;
    step();
    ready = 1'b1;
    for (int i = 0; i < 9; i++) step();

    // Both buffers full, new frame arrives on the final beat of the first.
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; data = seq_frame(100 + 10 * i);
      step();
    end
    en = 1'b0; ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    en = 1'b1; data = seq_frame(200);
    step();
    en = 1'b0;
    for (int i = 0; i < 9; i++) step();

    // Reset in the middle of a frame, then a fresh frame from slot 0.
    en = 1'b1; data = seq_frame(300);
    step();
    en = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_reset_valid", 32'(s_valid), 32'd0);
    step();
    en = 1'b1; data = seq_frame(400);
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 2) == 0);
      ready = ($urandom_range(0, 1) == 1);
      for (int w = 0; w < BW / 32; w++) data[32*w +: 32] = $urandom;
      step();
    end
    en = 1'b0; ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Natural order, N=8: samples 0x0100+k stream out in bus order.
    for (int k = 0; k < N8; k++) begin
      data8[2*DW*k +: DW]      = DW'(16'h0100 + k);
      data8[2*DW*k + DW +: DW] = DW'(16'h0200 + k);
    end
    @(posedge clk); #1;
    en8 = 1'b1;
    @(posedge clk); #1;
    en8 = 1'b0;
    for (int k = 0; k < N8; k++) begin
      @(negedge clk);
      check("n8_valid", 32'(s_valid8), 32'd1);
      check("n8_real",  32'(s_real8),  32'(16'h0100 + k));
      check("n8_imag",  32'(s_imag8),  32'(16'h0200 + k));
      check("n8_index", 32'(s_index8), 32'(k));
      check("n8_last",  32'(s_last8),  32'(k == N8 - 1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("n8_idle", 32'(s_valid8), 32'd0);
    check("n8_ovf",  32'(ovf8),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
